// File: rtl/bus_target.sv
// Synchronous bus target for the SYNC/DIN/DOUT/WTBT/RPLY system bus: address-window decode,
// wait-stated RAM port, reply. Optional `BUS_TARGET_WRITE_PROTECT_EN adds wp / wp_err.
module bus_target #(
  parameter logic [15:0] BASE        = 16'o100000,
  parameter logic [15:0] MASK        = 16'o170000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        sync,
  input  logic        din,
  input  logic        dout,
  input  logic        wtbt,
  input  logic [15:0] addr_i,
  input  logic [15:0] data_i,
  output logic [15:0] data_o,
  output logic        rply,
  output logic        sel,
  output logic [14:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
`ifdef BUS_TARGET_WRITE_PROTECT_EN
  input  logic        wp,
  output logic        wp_err,
`endif
  output logic [1:0]  dbg_state
);

  // Handshake: the master raises sync (with din or dout) and holds it for the whole
  // transaction; the target answers with rply, which stays up until sync is sampled low.
  // Dropping sync before rply aborts the transaction without side effects.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    REPLY  = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  state_t     state;
  logic [3:0] cnt;
  logic       is_write;
  logic       hit;
  logic       one_dir;
  logic       write_ok;
  logic [1:0] be_next;

  assign hit     = (addr_i & MASK) == (BASE & MASK);
  assign one_dir = din ^ dout;
  assign be_next = !wtbt ? 2'b11 : (addr_i[0] ? 2'b10 : 2'b01);

`ifdef BUS_TARGET_WRITE_PROTECT_EN
  assign write_ok = !wp;
`else
  assign write_ok = 1'b1;
`endif

  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      is_write  <= 1'b0;
      data_o    <= 16'd0;
      rply      <= 1'b0;
      sel       <= 1'b0;
      mem_addr  <= 15'd0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 2'b00;
      mem_wdata <= 16'd0;
`ifdef BUS_TARGET_WRITE_PROTECT_EN
      wp_err    <= 1'b0;
`endif
    end else if (ce) begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (sync && hit) begin
            sel <= 1'b1;
            if (one_dir) begin
              mem_addr  <= addr_i[15:1];
              mem_wdata <= data_i;
              mem_be    <= be_next;
              is_write  <= dout;
              mem_re    <= din;
              cnt       <= WS_LOAD;
              state     <= ACCESS;
            end else begin
              // Ambiguous request: claim the bus but never reply, so the master times out.
              state <= HOLD;
            end
          end
        end
        ACCESS: begin
          if (!sync) begin
            state  <= IDLE;
            sel    <= 1'b0;
            mem_re <= 1'b0;
          end else if (cnt == 4'd0) begin
            state  <= REPLY;
            rply   <= 1'b1;
            mem_re <= 1'b0;
            if (is_write) begin
              mem_we <= write_ok;
`ifdef BUS_TARGET_WRITE_PROTECT_EN
              if (!write_ok) wp_err <= 1'b1;
`endif
            end else begin
              data_o <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        REPLY: begin
          if (!sync) begin
            state  <= IDLE;
            rply   <= 1'b0;
            data_o <= 16'd0;
            sel    <= 1'b0;
          end
        end
        HOLD: begin
          if (!sync) begin
            state <= IDLE;
            sel   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_target.sv
// Self-checking bench for bus_target: one instance with 1 wait state, one with 4,
// sharing the master-side stimulus.
module tb_bus_target;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_REPLY  = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n, ce, sync, din, dout, wtbt, wp;
  logic [15:0] addr_i, data_i, mem_rdata;

  logic [15:0] data_o, mem_wdata, data_o_4, mem_wdata_4;
  logic        rply, sel, mem_re, mem_we, rply_4, sel_4, mem_re_4, mem_we_4;
  logic [14:0] mem_addr, mem_addr_4;
  logic [1:0]  mem_be, mem_be_4, dbg_state, dbg_state_4;
  logic        wp_err, wp_err_4;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] exp_q[$];
  logic [32:0] wexp_q[$];

  bus_target #(.BASE(16'o100000), .MASK(16'o170000), .WAIT_STATES(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .sync(sync), .din(din), .dout(dout),
    .wtbt(wtbt), .addr_i(addr_i), .data_i(data_i), .data_o(data_o), .rply(rply),
    .sel(sel), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef BUS_TARGET_WRITE_PROTECT_EN
    .wp(wp), .wp_err(wp_err),
`endif
    .dbg_state(dbg_state)
  );

  bus_target #(.BASE(16'o100000), .MASK(16'o170000), .WAIT_STATES(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .sync(sync), .din(din), .dout(dout),
    .wtbt(wtbt), .addr_i(addr_i), .data_i(data_i), .data_o(data_o_4), .rply(rply_4),
    .sel(sel_4), .mem_addr(mem_addr_4), .mem_re(mem_re_4), .mem_we(mem_we_4),
    .mem_be(mem_be_4), .mem_wdata(mem_wdata_4), .mem_rdata(mem_rdata),
`ifdef BUS_TARGET_WRITE_PROTECT_EN
    .wp(wp), .wp_err(wp_err_4),
`endif
    .dbg_state(dbg_state_4)
  );

`ifndef BUS_TARGET_WRITE_PROTECT_EN
  assign wp_err   = 1'b0;
  assign wp_err_4 = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_idle();
    sync = 1'b0; din = 1'b0; dout = 1'b0; wtbt = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ce = 1'b1; wp = 1'b0;
    bus_idle();
    addr_i = 16'd0; data_i = 16'd0; mem_rdata = 16'd0;
    step(2);
    n_vec++;
    if ({rply, sel, mem_re, mem_we, data_o, mem_addr, mem_be, mem_wdata} !== 52'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got rply=%b sel=%b re=%b we=%b data_o=%o addr=%o be=%b wdata=%o, want all 0",
               rply, sel, mem_re, mem_we, data_o, mem_addr, mem_be, mem_wdata);
    end
    n_vec++;
    if (dbg_state !== S_IDLE || dbg_state_4 !== S_IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d/%0d want %0d", dbg_state, dbg_state_4, S_IDLE);
    end
    n_vec++;
    if (wp_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_wp_err: got %b want 0", wp_err);
    end
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic test_word_read();
    addr_i = 16'o100002; mem_rdata = 16'o123456;
    sync = 1'b1; din = 1'b1;
    exp_q.push_back(16'o123456);
    step(1); // E0
    n_vec++;
    if (mem_addr !== 15'o40001 || sel !== 1'b1 || mem_re !== 1'b1 || rply !== 1'b0) begin
      n_err++;
      $display("FAIL word_read_e0: got addr=%o sel=%b re=%b rply=%b want 40001 1 1 0", mem_addr, sel, mem_re, rply);
    end
    step(1); // E1
    n_vec++;
    if (rply !== 1'b0) begin
      n_err++;
      $display("FAIL word_read_e1_rply: got %b want 0", rply);
    end
    step(1); // E2
    n_vec++;
    if (rply !== 1'b1 || mem_re !== 1'b0) begin
      n_err++;
      $display("FAIL word_read_e2: got rply=%b re=%b want 1 0", rply, mem_re);
    end
    n_vec++;
    if (data_o !== exp_q[0]) begin
      n_err++;
      $display("FAIL word_read_data: got %o want %o", data_o, exp_q[0]);
    end
    void'(exp_q.pop_front());
    mem_rdata = 16'o000777;
    step(2);
    n_vec++;
    if (rply !== 1'b1 || data_o !== 16'o123456) begin
      n_err++;
      $display("FAIL word_read_hold: got rply=%b data_o=%o want 1 123456", rply, data_o);
    end
    bus_idle();
    step(1);
    n_vec++;
    if (rply !== 1'b0 || data_o !== 16'd0 || sel !== 1'b0 || dbg_state !== S_IDLE) begin
      n_err++;
      $display("FAIL word_read_release: got rply=%b data_o=%o sel=%b st=%0d want 0 0 0 0", rply, data_o, sel, dbg_state);
    end
  endtask

  // Read on the 1-wait-state target with a bounded wait for rply.
  task automatic do_read(input logic [15:0] a, input logic [15:0] d);
    int edges;
    addr_i = a; mem_rdata = d;
    sync = 1'b1; din = 1'b1;
    exp_q.push_back(d);
    edges = 0;
    do begin
      step(1);
      edges++;
    end while (rply !== 1'b1 && edges < 20);
    n_vec++;
    if (edges != 3) begin
      n_err++;
      $display("FAIL read_latency a=%o: got %0d edges want 3", a, edges);
    end
    n_vec++;
    if (data_o !== exp_q[0] || mem_addr !== a[15:1]) begin
      n_err++;
      $display("FAIL read_data a=%o: got data=%o addr=%o want %o %o", a, data_o, mem_addr, exp_q[0], a[15:1]);
    end
    void'(exp_q.pop_front());
    bus_idle();
    step(1);
    n_vec++;
    if (rply !== 1'b0 || data_o !== 16'd0) begin
      n_err++;
      $display("FAIL read_release a=%o: got rply=%b data=%o want 0 0", a, rply, data_o);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic wt,
                          input logic [1:0] be, input logic expect_we);
    int edges;
    int we_cnt;
    logic [32:0] got;
    addr_i = a; data_i = d; wtbt = wt;
    sync = 1'b1; dout = 1'b1;
    if (expect_we) wexp_q.push_back({be, a[15:1], d});
    edges = 0; we_cnt = 0;
    do begin
      step(1);
      edges++;
      if (mem_we === 1'b1) begin
        we_cnt++;
        got = {mem_be, mem_addr, mem_wdata};
        n_vec++;
        if (wexp_q.size() == 0) begin
          n_err++;
          $display("FAIL write_unexpected a=%o: got %h with nothing expected", a, got);
        end else begin
          if (got !== wexp_q[0]) begin
            n_err++;
            $display("FAIL write_fields a=%o: got %h want %h", a, got, wexp_q[0]);
          end
          void'(wexp_q.pop_front());
        end
      end
    end while (rply !== 1'b1 && edges < 20);
    n_vec++;
    if (rply !== 1'b1 || data_o !== 16'd0) begin
      n_err++;
      $display("FAIL write_reply a=%o: got rply=%b data_o=%o after %0d edges want 1 0", a, rply, data_o, edges);
    end
    repeat (3) begin
      step(1);
      if (mem_we === 1'b1) we_cnt++;
    end
    n_vec++;
    if (rply !== 1'b1) begin
      n_err++;
      $display("FAIL write_rply_held a=%o: got %b want 1", a, rply);
    end
    n_vec++;
    if (we_cnt != (expect_we ? 1 : 0)) begin
      n_err++;
      $display("FAIL write_we_pulses a=%o: got %0d want %0d", a, we_cnt, expect_we ? 1 : 0);
    end
    bus_idle();
    step(1);
    n_vec++;
    if (rply !== 1'b0 || mem_be !== be || mem_wdata !== d) begin
      n_err++;
      $display("FAIL write_release a=%o: got rply=%b be=%b wdata=%o want 0 %b %o", a, rply, mem_be, mem_wdata, be, d);
    end
  endtask

  task automatic test_writes();
    do_write(16'o100005, 16'o052400, 1'b1, 2'b10, 1'b1);
    do_write(16'o100004, 16'o000252, 1'b1, 2'b01, 1'b1);
    do_write(16'o107776, 16'o177001, 1'b0, 2'b11, 1'b1);
  endtask

  task automatic test_miss();
    logic any;
    any = 1'b0;
    addr_i = 16'o040000; sync = 1'b1; din = 1'b1;
    repeat (64) begin
      step(1);
      any = any | rply | sel | mem_re | mem_we | rply_4 | sel_4 | mem_re_4 | mem_we_4;
    end
    n_vec++;
    if (any !== 1'b0 || dbg_state !== S_IDLE) begin
      n_err++;
      $display("FAIL miss_quiet: got activity=%b st=%0d want 0 0", any, dbg_state);
    end
    bus_idle();
    step(1);
  endtask

  task automatic test_wait_states();
    int edges;
    addr_i = 16'o100020; mem_rdata = 16'o070707;
    sync = 1'b1; din = 1'b1;
    edges = 0;
    do begin
      step(1);
      edges++;
    end while (rply_4 !== 1'b1 && edges < 30);
    n_vec++;
    if (edges != 6 || data_o_4 !== 16'o070707) begin
      n_err++;
      $display("FAIL ws4_read: got %0d edges data=%o want 6 070707", edges, data_o_4);
    end
    bus_idle();
    step(1);
  endtask

  task automatic test_abort();
    logic any;
    // read abort: sync drops while the 4-wait-state target is still in ACCESS
    addr_i = 16'o100010; sync = 1'b1; din = 1'b1;
    step(3);
    n_vec++;
    if (dbg_state_4 !== S_ACCESS || mem_re_4 !== 1'b1) begin
      n_err++;
      $display("FAIL abort_in_access: got st=%0d re=%b want 1 1", dbg_state_4, mem_re_4);
    end
    bus_idle();
    any = 1'b0;
    repeat (10) begin
      step(1);
      any = any | rply_4;
    end
    n_vec++;
    if (any !== 1'b0 || dbg_state_4 !== S_IDLE || mem_re_4 !== 1'b0 || sel_4 !== 1'b0) begin
      n_err++;
      $display("FAIL abort_read: got rply_seen=%b st=%0d re=%b sel=%b want 0 0 0 0", any, dbg_state_4, mem_re_4, sel_4);
    end
    // write abort: the unissued write is dropped
    addr_i = 16'o100012; data_i = 16'o111111; sync = 1'b1; dout = 1'b1;
    any = 1'b0;
    repeat (3) begin
      step(1);
      any = any | mem_we_4 | rply_4;
    end
    bus_idle();
    repeat (10) begin
      step(1);
      any = any | mem_we_4 | rply_4;
    end
    n_vec++;
    if (any !== 1'b0 || dbg_state_4 !== S_IDLE) begin
      n_err++;
      $display("FAIL abort_write: got we_or_rply=%b st=%0d want 0 0", any, dbg_state_4);
    end
  endtask

  task automatic test_reset_in_reply();
    addr_i = 16'o100030; mem_rdata = 16'o000123; sync = 1'b1; din = 1'b1;
    step(3);
    n_vec++;
    if (rply !== 1'b1 || dbg_state !== S_REPLY || mem_re_4 !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset: got rply=%b st=%0d re4=%b want 1 2 1", rply, dbg_state, mem_re_4);
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if (rply !== 1'b0 || dbg_state !== S_IDLE || mem_re_4 !== 1'b0 || data_o !== 16'd0) begin
      n_err++;
      $display("FAIL async_reset: got rply=%b st=%0d re4=%b data=%o want 0 0 0 0", rply, dbg_state, mem_re_4, data_o);
    end
    bus_idle();
    step(1);
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic test_hold();
    logic any;
    addr_i = 16'o100000; sync = 1'b1; din = 1'b1; dout = 1'b1;
    step(1);
    n_vec++;
    if (dbg_state !== S_HOLD || sel !== 1'b1) begin
      n_err++;
      $display("FAIL hold_enter: got st=%0d sel=%b want 3 1", dbg_state, sel);
    end
    any = 1'b0;
    repeat (5) begin
      step(1);
      any = any | rply | mem_re | mem_we;
    end
    n_vec++;
    if (any !== 1'b0 || dbg_state !== S_HOLD) begin
      n_err++;
      $display("FAIL hold_quiet: got activity=%b st=%0d want 0 3", any, dbg_state);
    end
    bus_idle();
    step(1);
    n_vec++;
    if (dbg_state !== S_IDLE || sel !== 1'b0) begin
      n_err++;
      $display("FAIL hold_exit: got st=%0d sel=%b want 0 0", dbg_state, sel);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      do_read(16'(16'o100000 + $urandom_range(0, 4095)), 16'($urandom_range(0, 65535)));
    end
  endtask

  task automatic test_ce_freeze();
    addr_i = 16'o100040; mem_rdata = 16'o155555; sync = 1'b1; din = 1'b1;
    step(1);
    ce = 1'b0;
    step(5);
    n_vec++;
    if (dbg_state !== S_ACCESS || rply !== 1'b0 || mem_re !== 1'b1) begin
      n_err++;
      $display("FAIL ce_freeze: got st=%0d rply=%b re=%b want 1 0 1", dbg_state, rply, mem_re);
    end
    ce = 1'b1;
    step(1);
    n_vec++;
    if (rply !== 1'b0) begin
      n_err++;
      $display("FAIL ce_resume_e1: got rply=%b want 0", rply);
    end
    step(1);
    n_vec++;
    if (rply !== 1'b1 || data_o !== 16'o155555) begin
      n_err++;
      $display("FAIL ce_resume_e2: got rply=%b data=%o want 1 155555", rply, data_o);
    end
    bus_idle();
    step(1);
  endtask

`ifdef BUS_TARGET_WRITE_PROTECT_EN
  task automatic test_write_protect();
    wp = 1'b1;
    do_write(16'o100100, 16'o012345, 1'b0, 2'b11, 1'b0);
    n_vec++;
    if (wp_err !== 1'b1) begin
      n_err++;
      $display("FAIL wp_err_set: got %b want 1", wp_err);
    end
    wp = 1'b0;
    step(3);
    n_vec++;
    if (wp_err !== 1'b1) begin
      n_err++;
      $display("FAIL wp_err_sticky: got %b want 1", wp_err);
    end
    reset_n = 1'b0;
    step(1);
    n_vec++;
    if (wp_err !== 1'b0) begin
      n_err++;
      $display("FAIL wp_err_reset: got %b want 0", wp_err);
    end
    reset_n = 1'b1;
    step(1);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_word_read();
    test_writes();
    test_miss();
    test_wait_states();
    test_abort();
    test_reset_in_reply();
    test_hold();
    test_back_to_back();
    test_ce_freeze();
`ifdef BUS_TARGET_WRITE_PROTECT_EN
    test_write_protect();
`endif
    n_vec++;
    if (exp_q.size() != 0 || wexp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d/%0d entries left want 0/0", exp_q.size(), wexp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
